cam_capture: RTL and testbench

//  Front-end camera capture stage, directly upstream of the Sobel line buffer inside app.

---
 rtl/cam_capture.sv | 172 +++++++++++++++++
 tb/tb_cam_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// OV7670 capture front-end: synchronises the camera bus into clk, keeps the Y byte
// of every YUV422 pair and emits registered luma pixels with column/row and frame/line markers.
module cam_capture #(
  parameter int WIDTH_SOBEL = 320,
  parameter int HEIGHT      = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_hw,
  input  logic       PCLK,
  input  logic       Href,
  input  logic       VSYNC,
  input  logic [7:0] in_pixel,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  output logic       sol,
  output logic       sof,
  output logic       eol,
  output logic       frame_done,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       err_ovf
);

  typedef enum logic [1:0] {S_WAIT_VS_HI, S_WAIT_VS_LO, S_ACTIVE} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] pclk_p, href_p, vs_p;
  logic [7:0]             pix_p [SYNC_STAGES];
  logic                   pclk_d, href_d, vs_d;
  logic                   pclk_s, href_s, vs_s;
  logic [7:0]             pix_s;

  // One registered event stage between the synchronisers and the capture logic.
  logic       ev_pclk, ev_href_rise, ev_href_fall, ev_vs_rise, ev_href, ev_vs;
  logic [7:0] ev_byte;

  logic [9:0] col_cnt, row_cnt, col_eff;
  logic       phase, phase_eff, first_line, line_any, frame_any;

  assign pclk_s = pclk_p[SYNC_STAGES-1];
  assign href_s = href_p[SYNC_STAGES-1];
  assign vs_s   = vs_p[SYNC_STAGES-1];
  assign pix_s  = pix_p[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst_hw) begin
      pclk_p <= '0;
      href_p <= '0;
      vs_p   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) pix_p[i] <= '0;
      pclk_d <= 1'b0;
      href_d <= 1'b0;
      vs_d   <= 1'b0;
      ev_pclk      <= 1'b0;
      ev_href_rise <= 1'b0;
      ev_href_fall <= 1'b0;
      ev_vs_rise   <= 1'b0;
      ev_href      <= 1'b0;
      ev_vs        <= 1'b0;
      ev_byte      <= '0;
    end else begin
      pclk_p <= {pclk_p[SYNC_STAGES-2:0], PCLK};
      href_p <= {href_p[SYNC_STAGES-2:0], Href};
      vs_p   <= {vs_p[SYNC_STAGES-2:0], VSYNC};
      pix_p[0] <= in_pixel;
      for (int i = 1; i < SYNC_STAGES; i++) pix_p[i] <= pix_p[i-1];
      pclk_d <= pclk_s;
      href_d <= href_s;
      vs_d   <= vs_s;
      ev_pclk      <= pclk_s & ~pclk_d;
      ev_href_rise <= href_s & ~href_d;
      ev_href_fall <= ~href_s & href_d;
      ev_vs_rise   <= vs_s & ~vs_d;
      ev_href      <= href_s;
      ev_vs        <= vs_s;
      ev_byte      <= pix_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_hw) state <= S_WAIT_VS_HI;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    // A line start in the same cycle as a byte restarts the counters before the byte lands.
    col_eff    = ev_href_rise ? 10'd0 : col_cnt;
    phase_eff  = ev_href_rise ? 1'b0  : phase;
    case (state)
      S_WAIT_VS_HI: if (ev_vs)      state_next = S_WAIT_VS_LO;
      S_WAIT_VS_LO: if (!ev_vs)     state_next = S_ACTIVE;
      S_ACTIVE:     if (ev_vs_rise) state_next = S_WAIT_VS_LO;
      default:                      state_next = S_WAIT_VS_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_hw) begin
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      sol        <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
      err_ovf    <= 1'b0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      phase      <= 1'b0;
      first_line <= 1'b0;
      line_any   <= 1'b0;
      frame_any  <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      sol        <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_WAIT_VS_LO: if (!ev_vs) begin
          row_cnt    <= '0;
          col_cnt    <= '0;
          phase      <= 1'b0;
          err_ovf    <= 1'b0;
          first_line <= 1'b1;
          line_any   <= 1'b0;
          frame_any  <= 1'b0;
        end
        S_ACTIVE: begin
          if (ev_vs_rise) begin
            // Frame end aborts any line in progress without an eol.
            if (frame_any) frame_done <= 1'b1;
          end else begin
            if (ev_href_rise) begin
              col_cnt  <= '0;
              phase    <= 1'b0;
              line_any <= 1'b0;
            end
            if (ev_pclk && ev_href) begin
              phase <= ~phase_eff;
              if (!phase_eff) begin
                if (col_eff < 10'(WIDTH_SOBEL)) begin
                  pix_data  <= ev_byte;
                  pix_valid <= 1'b1;
                  col       <= col_eff;
                  row       <= row_cnt;
                  sol       <= (col_eff == 10'd0);
                  sof       <= first_line && (col_eff == 10'd0);
                  col_cnt   <= col_eff + 10'd1;
                  line_any  <= 1'b1;
                  frame_any <= 1'b1;
                end else begin
                  err_ovf <= 1'b1;
                end
              end
            end
            if (ev_href_fall && line_any) begin
              eol        <= 1'b1;
              first_line <= 1'b0;
              if (row_cnt != 10'(HEIGHT - 1)) row_cnt <= row_cnt + 10'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: drives OV7670-style frames and checks emitted luma pixels
// against an expected queue, plus line/frame markers, overflow flag, reset and latency.
module tb_cam_capture;

  localparam int W  = 8;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_hw, PCLK, Href, VSYNC;
  logic [7:0] in_pixel;
  logic [7:0] pix_data;
  logic       pix_valid, sol, sof, eol, frame_done, err_ovf;
  logic [9:0] col, row;

  cam_capture #(.WIDTH_SOBEL(W), .HEIGHT(240), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_hw(rst_hw), .PCLK(PCLK), .Href(Href), .VSYNC(VSYNC),
    .in_pixel(in_pixel), .pix_data(pix_data), .pix_valid(pix_valid),
    .sol(sol), .sof(sof), .eol(eol), .frame_done(frame_done),
    .col(col), .row(row), .err_ovf(err_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int y_rise_cyc = 0;
  int eol_cnt = 0;
  int fd_cnt  = 0;
  int exp_eol = 0;
  int exp_fd  = 0;

  // {data, col, row, sol, sof}
  logic [29:0] exp_q[$];

  // bench model of capture state
  bit m_armed, m_active, m_frame_any, m_first;
  int m_row;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard / monitor
  always @(posedge clk) begin
    #1;
    if (eol) eol_cnt++;
    if (frame_done) fd_cnt++;
    if (pix_valid) begin
      check("latency", cyc - y_rise_cyc, SS + 2);
      if (exp_q.size() == 0) check("unexpected_pix", {24'd0, pix_data}, 32'hFFFF_FFFF);
      else check("pixel", {2'd0, pix_data, col, row, sol, sof}, {2'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_vsync(input logic v);
    VSYNC = v;
    if (v) begin
      if (m_active && m_frame_any) exp_fd++;
      m_active = 0;
      m_armed  = 1;
    end else if (m_armed) begin
      m_armed = 0;
      m_active = 1;
      m_row = 0;
      m_first = 1;
      m_frame_any = 0;
    end
  endtask

  task automatic vsync_pulse();
    set_vsync(1'b1);
    wait_clk(12);
    set_vsync(1'b0);
    wait_clk(12);
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit is_y);
    in_pixel = b;
    PCLK = 1'b0;
    wait_clk(4);
    PCLK = 1'b1;
    if (is_y) y_rise_cyc = cyc;
    wait_clk(4);
  endtask

  // One Y/chroma pair; k is the pixel index within the line.
  task automatic drive_pixel(input logic [7:0] y, input int k);
    if (m_active && k < W) begin
      exp_q.push_back({y, 10'(k), 10'(m_row), k == 0, m_first && k == 0});
      m_frame_any = 1;
    end
    drive_byte(y, 1'b1);
    drive_byte(8'h80 + 8'(k), 1'b0);
  endtask

  task automatic line_start();
    PCLK = 1'b0;
    Href = 1'b1;
    wait_clk(4);
  endtask

  task automatic line_end(input int n);
    PCLK = 1'b0;
    Href = 1'b0;
    if (m_active && n > 0) begin
      exp_eol++;
      m_first = 0;
      m_row++;
    end
    wait_clk(10);
  endtask

  task automatic drive_line(input int base, input int n);
    line_start();
    for (int k = 0; k < n; k++) drive_pixel(8'(base + k), k);
    line_end(n);
  endtask

  initial begin
    rst_hw = 1'b1; PCLK = 1'b0; Href = 1'b0; VSYNC = 1'b0; in_pixel = '0;
    m_armed = 0; m_active = 0; m_frame_any = 0; m_first = 0; m_row = 0;
    wait_clk(3);
    rst_hw = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    check("rst_col", col, 0);
    check("rst_row", row, 0);
    check("rst_ovf", err_ovf, 0);
    @(negedge clk);

    // T3: bytes before any VSYNC are ignored
    drive_line(100, 4);
    check("t3_eol", eol_cnt, 0);

    // T1: one full line of 8 pixels
    vsync_pulse();
    drive_line(0, 8);
    check("t1_eol", eol_cnt, exp_eol);
    check("t1_ovf", err_ovf, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // T2: four overlong lines then frame end
    vsync_pulse();
    check("t2_fd_prev", fd_cnt, exp_fd);
    for (int l = 0; l < 4; l++) drive_line(l * 10, 10);
    check("t2_eol", eol_cnt, exp_eol);
    check("t2_ovf", err_ovf, 1);
    check("t2_last_row", row, 3);
    vsync_pulse();
    check("t2_fd", fd_cnt, exp_fd);
    check("t2_ovf_clr", err_ovf, 0);

    // T4: reset in the middle of line 2
    drive_line(50, 8);
    line_start();
    drive_pixel(8'd60, 0);
    drive_pixel(8'd61, 1);
    rst_hw = 1'b1;
    m_active = 0; m_armed = 0;
    @(posedge clk); #1;
    check("t4_rst_data", pix_data, 0);
    check("t4_rst_col", col, 0);
    check("t4_rst_row", row, 0);
    @(negedge clk);
    rst_hw = 1'b0;
    for (int k = 2; k < 6; k++) drive_pixel(8'(60 + k), k);
    line_end(6);
    drive_line(70, 5);
    check("t4_eol", eol_cnt, exp_eol);
    check("t4_fd", fd_cnt, exp_fd);
    vsync_pulse();
    drive_line(200, 8);
    check("t4_resume_row", row, 0);

    // T5: VSYNC mid-line aborts the line
    vsync_pulse();
    line_start();
    for (int k = 0; k < 3; k++) drive_pixel(8'(150 + k), k);
    set_vsync(1'b1);
    for (int k = 3; k < 6; k++) drive_pixel(8'(150 + k), k);
    line_end(6);
    check("t5_eol", eol_cnt, exp_eol);
    check("t5_fd", fd_cnt, exp_fd);
    set_vsync(1'b0);
    wait_clk(12);
    drive_line(180, 8);
    check("t5_restart_row", row, 0);

    // T6: random lengths and data; latency checked on every pixel
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      int n;
      int b;
      n = $urandom_range(1, W + 2);
      b = $urandom_range(0, 200);
      drive_line(b, n);
    end
    vsync_pulse();
    check("t6_eol", eol_cnt, exp_eol);
    check("t6_fd", fd_cnt, exp_fd);
    wait_clk(10);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
